// File: rtl/seven_seg_scan_n.sv
// Multiplexed common-anode seven-segment scanner with frame-coherent shadowing,
// leading-zero blanking and PWM brightness on the anode enables.
module seven_seg_scan_n #(
   parameter int NUM_DIGITS = 4,
   parameter int DIM_BITS   = 3
) (
   input  logic                    clk1,
   input  logic                    reset,
   input  logic                    refresh,
   input  logic [4*NUM_DIGITS-1:0] word,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    blank_lz,
   input  logic [DIM_BITS-1:0]     brightness,
   output logic [6:0]              cath_out,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic                    frame_done
);

   localparam logic [2:0] DIG_MAX = 3'(NUM_DIGITS - 1);

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'b0000001;
         4'h1:    seg = 7'b1001111;
         4'h2:    seg = 7'b0010010;
         4'h3:    seg = 7'b0000110;
         4'h4:    seg = 7'b1001100;
         4'h5:    seg = 7'b0100100;
         4'h6:    seg = 7'b0100000;
         4'h7:    seg = 7'b0001111;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0000100;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b1100000;
         4'hC:    seg = 7'b0110001;
         4'hD:    seg = 7'b1000010;
         4'hE:    seg = 7'b0110000;
         4'hF:    seg = 7'b0111000;
         default: seg = 7'b1111111;
      endcase
      return seg;
   endfunction

   logic                    q1_r, q2_r;
   logic [2:0]              dig_r;
   logic [DIM_BITS-1:0]     pwm_cnt_r;
   logic [4*NUM_DIGITS-1:0] shadow_word_r;
   logic [NUM_DIGITS-1:0]   shadow_dp_r;
   logic                    frame_done_r;
   logic [NUM_DIGITS-1:0]   anode_r;
   logic [6:0]              cath_r;
   logic                    dp_r;

   logic                    step_s, wrap_s, on_s, blank_s;
   logic                    zero_run_s, cur_lz_s, cur_dp_s;
   logic [3:0]              cur_nib_s;
   logic [NUM_DIGITS-1:0]   dig_sel_s;

   assign step_s = q1_r & ~q2_r;
   assign wrap_s = step_s && (dig_r == 3'd0);
   assign on_s   = (pwm_cnt_r <= brightness);

   // Refresh edge synchroniser and free-running PWM counter.
   always_ff @(posedge clk1) begin
      if (reset) begin
         q1_r      <= 1'b0;
         q2_r      <= 1'b0;
         pwm_cnt_r <= '0;
      end else begin
         q1_r      <= refresh;
         q2_r      <= q1_r;
         pwm_cnt_r <= pwm_cnt_r + 1'b1;
      end
   end

   // Scan counter; the wrap edge reloads the shadow and flags frame completion.
   always_ff @(posedge clk1) begin
      if (reset) begin
         dig_r         <= DIG_MAX;
         shadow_word_r <= '0;
         shadow_dp_r   <= '0;
         frame_done_r  <= 1'b0;
      end else begin
         frame_done_r <= wrap_s;
         if (wrap_s) begin
            dig_r         <= DIG_MAX;
            shadow_word_r <= word;
            shadow_dp_r   <= dp_in;
         end else if (step_s) begin
            dig_r <= dig_r - 3'd1;
         end else begin
            dig_r <= dig_r;
         end
      end
   end

   // Select the current nibble and track whether it and every digit to its left are zero.
   always_comb begin
      zero_run_s = 1'b1;
      cur_lz_s   = 1'b0;
      cur_dp_s   = 1'b0;
      cur_nib_s  = 4'h0;
      dig_sel_s  = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run_s = zero_run_s & (shadow_word_r[4*i +: 4] == 4'h0);
         if (dig_r == 3'(i)) begin
            cur_nib_s    = shadow_word_r[4*i +: 4];
            cur_dp_s     = shadow_dp_r[i];
            cur_lz_s     = zero_run_s;
            dig_sel_s[i] = 1'b1;
         end else begin
            dig_sel_s[i] = 1'b0;
         end
      end
      blank_s = blank_lz && (dig_r != 3'd0) && cur_lz_s;
   end

   // Registered pin drive; PWM gates only the anodes.
   always_ff @(posedge clk1) begin
      if (reset) begin
         anode_r <= '1;
         cath_r  <= 7'b1111111;
         dp_r    <= 1'b1;
      end else begin
         anode_r <= on_s ? ~dig_sel_s : '1;
         cath_r  <= blank_s ? 7'b1111111 : seg_decode(cur_nib_s);
         dp_r    <= ~cur_dp_s;
      end
   end

   assign cath_out   = cath_r;
   assign dp_out     = dp_r;
   assign anode      = anode_r;
   assign frame_done = frame_done_r;

endmodule
